alu_result_stage: RTL and testbench

//  Downstream stage of the ALU datapath. Consumes the combinational ALU and shifter results and owns the HI/LO pair.

---
 rtl/alu_defs_pkg.sv | 23 ++
 rtl/multu_seq.sv | 50 +++++
 rtl/alu_result_stage.sv | 104 ++++++++++
 tb/tb_alu_result_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
// rtl/alu_defs_pkg.sv - shared funct codes, sizes and FSM encoding for the ALU result stage
package alu_defs_pkg;

  localparam int WIDTH   = 32;
  localparam int MUL_CYC = 32;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULTU = 6'b011001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/multu_seq.sv
// rtl/multu_seq.sv - shift-add unsigned multiplier datapath, one iteration per cycle
module multu_seq
  import alu_defs_pkg::*;
#(
  parameter int W   = WIDTH,
  parameter int CYC = MUL_CYC
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           run,
  input  logic [W-1:0]   mcand_in,
  input  logic [W-1:0]   mplier_in,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(CYC);

  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [CW-1:0]  count_q;

  // product is the accumulator after this cycle's add, so the last iteration's
  // result can be written to HI/LO on the same edge that ends it
  assign product = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign done    = run && (count_q == CW'(CYC - 1));

  // operand latch on start, then add/shift/count every running cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{W{1'b0}}, mcand_in};
      mplier_q <= mplier_in;
      count_q  <= '0;
    end else if (run) begin
      acc_q    <= product;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result register stage with HI/LO and sequential MULTU
module alu_result_stage
  import alu_defs_pkg::*;
#(
  parameter int W   = WIDTH,
  parameter int CYC = MUL_CYC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inValid,
  output logic         inReady,
  input  logic [5:0]   Signal,
  input  logic [W-1:0] dataA,
  input  logic [W-1:0] dataB,
  input  logic [W-1:0] aluOut,
  input  logic [W-1:0] shifterOut,
  output logic [W-1:0] dataOut,
  output logic         outValid,
  output logic         mulDone,
  output logic         errFunct
);

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;
  logic [W-1:0]   result;
  logic           known;
  logic           accept;
  logic           start_mul;
  logic           mul_fin;
  logic [2*W-1:0] product;

  assign inReady   = (state_q == ST_IDLE);
  assign accept    = inValid && inReady;
  assign start_mul = accept && (Signal == FN_MULTU);

  multu_seq #(.W(W), .CYC(CYC)) u_multu (
    .clk       (clk),
    .reset     (reset),
    .start     (start_mul),
    .run       (state_q == ST_MUL),
    .mcand_in  (dataA),
    .mplier_in (dataB),
    .done      (mul_fin),
    .product   (product)
  );

  // result select by funct; unknown codes yield zero and flag an error
  always_comb begin
    result = '0;
    known  = 1'b1;
    case (Signal)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: result = aluOut;
      FN_SLL, FN_SRL:                        result = shifterOut;
      FN_MFHI:                               result = hi_q;
      FN_MFLO:                               result = lo_q;
      FN_MULTU:                              result = '0;
      default:                               known  = 1'b0;
    endcase
  end

  // next-state: leave IDLE on an accepted MULTU, return when the last iteration ends
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_mul) state_d = ST_MUL;
      ST_MUL:  if (mul_fin)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // HI/LO, output register and single-cycle status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      dataOut  <= '0;
      outValid <= 1'b0;
      mulDone  <= 1'b0;
      errFunct <= 1'b0;
    end else begin
      outValid <= 1'b0;
      errFunct <= 1'b0;
      mulDone  <= mul_fin;
      if (mul_fin) begin
        hi_q <= product[2*W-1:W];
        lo_q <= product[W-1:0];
      end
      if (accept && !start_mul) begin
        dataOut  <= result;
        outValid <= 1'b1;
        errFunct <= !known;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed self-checking bench for alu_result_stage
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] aluOut;
  logic [31:0] shifterOut;
  logic [31:0] dataOut;
  logic        outValid;
  logic        mulDone;
  logic        errFunct;

  int vectors = 0;
  int errors  = 0;

  alu_result_stage dut (
    .clk        (clk),
    .reset      (reset),
    .inValid    (inValid),
    .inReady    (inReady),
    .Signal     (Signal),
    .dataA      (dataA),
    .dataB      (dataB),
    .aluOut     (aluOut),
    .shifterOut (shifterOut),
    .dataOut    (dataOut),
    .outValid   (outValid),
    .mulDone    (mulDone),
    .errFunct   (errFunct)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; inValid = 1'b1; Signal = 6'b100000; aluOut = 32'h77;
    dataA = '0; dataB = '0; shifterOut = '0;
    step();
    step();
    reset = 1'b0; inValid = 1'b0;
    vectors++;
    if (dataOut !== 32'h0 || outValid !== 1'b0 || mulDone !== 1'b0 ||
        errFunct !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: dataOut=%h outValid=%b mulDone=%b errFunct=%b inReady=%b, want 0/0/0/0/1",
               dataOut, outValid, mulDone, errFunct, inReady);
    end
    step();
    vectors++;
    if (outValid !== 1'b0 || dataOut !== 32'h0) begin
      errors++;
      $display("FAIL reset_drops_op: outValid=%b dataOut=%h, want 0/00000000", outValid, dataOut);
    end
  endtask

  task automatic test_sll();
    inValid = 1'b1; Signal = 6'b000000; shifterOut = 32'h10; aluOut = 32'hAAAA_AAAA;
    step();
    inValid = 1'b0;
    vectors++;
    if (dataOut !== 32'h10 || outValid !== 1'b1) begin
      errors++;
      $display("FAIL sll: dataOut=%h outValid=%b, want 00000010/1", dataOut, outValid);
    end
    step();
    vectors++;
    if (outValid !== 1'b0) begin
      errors++;
      $display("FAIL sll_pulse: outValid=%b, want 0", outValid);
    end
  endtask

  // start a multiply, count busy cycles, then read HI and LO back-to-back
  task automatic test_multu(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] prev;
    int busy;
    prev = dataOut;
    inValid = 1'b1; Signal = 6'b011001; dataA = a; dataB = b;
    step();
    inValid = 1'b0;
    busy = 0;
    while (!inReady && busy < 40) begin
      busy++;
      step();
    end
    vectors++;
    if (busy !== 32) begin
      errors++;
      $display("FAIL multu_busy %h*%h: busy cycles=%0d, want 32", a, b, busy);
    end
    vectors++;
    if (mulDone !== 1'b1 || outValid !== 1'b0 || dataOut !== prev) begin
      errors++;
      $display("FAIL multu_done %h*%h: mulDone=%b outValid=%b dataOut=%h, want 1/0/%h",
               a, b, mulDone, outValid, dataOut, prev);
    end
    inValid = 1'b1; Signal = 6'b010000;
    step();
    Signal = 6'b010010;
    vectors++;
    if (dataOut !== exp_hi || outValid !== 1'b1 || mulDone !== 1'b0) begin
      errors++;
      $display("FAIL mfhi %h*%h: dataOut=%h outValid=%b mulDone=%b, want %h/1/0",
               a, b, dataOut, outValid, mulDone, exp_hi);
    end
    step();
    inValid = 1'b0;
    vectors++;
    if (dataOut !== exp_lo || outValid !== 1'b1) begin
      errors++;
      $display("FAIL mflo %h*%h: dataOut=%h outValid=%b, want %h/1", a, b, dataOut, outValid, exp_lo);
    end
  endtask

  task automatic test_backpressure();
    int early;
    int n;
    inValid = 1'b1; Signal = 6'b011001; dataA = 32'd2; dataB = 32'd3;
    step();
    Signal = 6'b100000; aluOut = 32'h5;
    early = 0; n = 0;
    while (!inReady && n < 40) begin
      if (outValid !== 1'b0) early++;
      n++;
      step();
    end
    vectors++;
    if (early !== 0 || n !== 32) begin
      errors++;
      $display("FAIL bp_hold: early outValid=%0d busy=%0d, want 0/32", early, n);
    end
    vectors++;
    if (mulDone !== 1'b1) begin
      errors++;
      $display("FAIL bp_muldone: mulDone=%b, want 1", mulDone);
    end
    step();
    inValid = 1'b0;
    vectors++;
    if (dataOut !== 32'h5 || outValid !== 1'b1) begin
      errors++;
      $display("FAIL bp_add: dataOut=%h outValid=%b, want 00000005/1", dataOut, outValid);
    end
  endtask

  task automatic test_reset_mid_mul();
    int done_seen;
    inValid = 1'b1; Signal = 6'b011001; dataA = 32'd3; dataB = 32'd5;
    step();
    inValid = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (inReady !== 1'b1 || mulDone !== 1'b0) begin
      errors++;
      $display("FAIL rst_mul_state: inReady=%b mulDone=%b, want 1/0", inReady, mulDone);
    end
    done_seen = 0;
    repeat (40) begin
      if (mulDone !== 1'b0) done_seen++;
      step();
    end
    vectors++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL rst_mul_nodone: mulDone pulses=%0d, want 0", done_seen);
    end
    inValid = 1'b1; Signal = 6'b010010;
    step();
    inValid = 1'b0;
    vectors++;
    if (dataOut !== 32'h0 || outValid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mul_mflo: dataOut=%h outValid=%b, want 00000000/1", dataOut, outValid);
    end
  endtask

  task automatic test_unknown();
    inValid = 1'b1; Signal = 6'b111111; aluOut = 32'hDEAD_BEEF; shifterOut = 32'h1234_5678;
    step();
    Signal = 6'b100010; aluOut = 32'h0000_0042;
    vectors++;
    if (outValid !== 1'b1 || errFunct !== 1'b1 || dataOut !== 32'h0) begin
      errors++;
      $display("FAIL unknown: outValid=%b errFunct=%b dataOut=%h, want 1/1/00000000",
               outValid, errFunct, dataOut);
    end
    step();
    inValid = 1'b0;
    vectors++;
    if (errFunct !== 1'b0 || dataOut !== 32'h42 || outValid !== 1'b1) begin
      errors++;
      $display("FAIL unknown_clear: errFunct=%b dataOut=%h outValid=%b, want 0/00000042/1",
               errFunct, dataOut, outValid);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  sig_t [6];
    logic [31:0] alu_t [6];
    logic [31:0] sh_t  [6];
    logic [31:0] exp_t [6];
    sig_t = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000010};
    alu_t = '{32'h0000_0011, 32'hFFFF_FFFE, 32'h0F0F_0000, 32'h1234_5678, 32'h0000_0001, 32'h9999_9999};
    sh_t  = '{32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h0000_7FFF};
    exp_t = '{32'h0000_0011, 32'hFFFF_FFFE, 32'h0F0F_0000, 32'h1234_5678, 32'h0000_0001, 32'h0000_7FFF};
    inValid = 1'b1; Signal = sig_t[0]; aluOut = alu_t[0]; shifterOut = sh_t[0];
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (dataOut !== exp_t[i] || outValid !== 1'b1 || inReady !== 1'b1 || errFunct !== 1'b0) begin
        errors++;
        $display("FAIL b2b[%0d]: dataOut=%h outValid=%b inReady=%b errFunct=%b, want %h/1/1/0",
                 i, dataOut, outValid, inReady, errFunct, exp_t[i]);
      end
      if (i < 5) begin
        Signal = sig_t[i+1]; aluOut = alu_t[i+1]; shifterOut = sh_t[i+1];
      end else begin
        inValid = 1'b0;
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sll();
    test_multu(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    test_multu(32'h0001_2345, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    test_multu(32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 32'h0000_002A);
    test_multu(32'h8000_0001, 32'h0000_0010, 32'h0000_0008, 32'h0000_0010);
    test_backpressure();
    test_reset_mid_mul();
    test_unknown();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
